vgpr_rd_port_arbiter_8: RTL and testbench
=========================================

// Module: vgpr_rd_port_arbiter_8
// PURPOSE
//  Round-robin arbiter in front of rd_port_mux_8to1. It takes up to 8 simultaneous VGPR read requests
//  and drives exactly one (or zero) one-hot portN_rd_en/portN_rd_addr pair per cycle into the mux,
//  guaranteeing the mux never sees a multi-hot enable. It tracks each granted read through the
//  register-file latency and raises a one-hot data-valid strobe so requesters know when rd_data is theirs.
// PARAMETERS
//  NUM_PORTS   8   requesters; fixed by the 8to1 mux (not generic beyond 8)
//  ADDR_W      10  VGPR read address width
//  RD_LATENCY  1   cycles from rd_en asserted at mux to muxed_port_rd_data valid (1..4)
// PORTS
//  clk             in   1         core clock
//  rst             in   1         synchronous reset, active-low
//  req             in   8         per-port read request; held high until gnt
//  req_addr        in   8*ADDR_W  per-port address; port i at [i*ADDR_W +: ADDR_W]; stable while req
//  gnt             out  8         one-hot grant; req consumed in the cycle gnt[i]=1
//  port0..7_rd_en  out  1 each    to mux; equals gnt[i]
//  port0..7_rd_addr out ADDR_W    to mux; req_addr slice i when granted, else 0
//  rd_data_vld     out  8         one-hot; rd_data (mux output) belongs to port i this cycle
//  busy            out  1         any read in flight in the latency pipe
// BEHAVIOUR
//  - Reset (rst==0 at posedge): rr_ptr<=0, latency pipe cleared, rd_data_vld<=0, busy<=0.
//    gnt/rd_en are combinational but forced 0 while rst==0.
//  - Grant: combinational from req and registered rr_ptr; scan ports rr_ptr, rr_ptr+1, ... mod 8;
//    first asserted req wins. gnt is always $onehot0. No req -> gnt=0, all rd_en=0, addrs 0.
//  - Pointer: on a grant to port k, rr_ptr<=(k+1) mod 8 (wrap 7->0); no grant -> rr_ptr holds.
//  - Fairness: a continuously asserted req is granted within 8 cycles.
//  - Handshake: requester samples gnt at posedge; on gnt it may drop req or present a new addr
//    next cycle. Back-to-back grants to the same port allowed only when no other port requests.
//  - Latency pipe: RD_LATENCY-deep shift register of {valid, port_id[2:0]} loaded with the grant.
//    rd_data_vld[id]=1 exactly RD_LATENCY cycles after the gnt cycle; registered output.
//    One read issued per cycle max, so at most one vld bit per cycle; throughput 1 read/clk.
//  - busy = OR of pipe valid bits.
//  - Reset mid-operation: in-flight reads discarded, no vld ever emitted for them.
//  - Simultaneous: all 8 req with rr_ptr=5 -> grant order 5,6,7,0,1,2,3,4 over 8 cycles.
//  - req_addr of non-granted ports is ignored; X on it must not reach rd_addr outputs.
// CONFIGURATION
//  Macro VGPR_RD_ARB_PERF_CNT_EN:
//   defined: extra outputs perf_grant_cnt[31:0] (increments on each grant) and
//            perf_conflict_cnt[31:0] (increments each cycle with >=2 req bits set);
//            both saturate at 32'hFFFF_FFFF, cleared by rst.
//   undefined: ports and counters absent; arbitration identical.
// STRUCTURE
//  - Shared definitions file: `define VGPR_RD_PORTS 8, `define VGPR_RD_PORT_ID_W 3,
//    `define VGPR_RD_ADDR_W 10 alongside the existing issue/lsu definitions.
//  - One sub-module: rr_arbiter_8 (req[7:0], ptr[2:0] -> gnt[7:0], gnt_id[2:0]), purely
//    combinational, reusable for other 8-way register-file ports.
//  - Top holds rr_ptr, latency pipe, output slicing, optional counters.
// TESTING
//  1 Single req: req=8'h04, addr2=10'h155 -> gnt=8'h04, port2_rd_en=1, port2_rd_addr=10'h155,
//    other rd_en 0; rd_data_vld=8'h04 one cycle later (RD_LATENCY=1), busy=1 in between.
//  2 All req held, rr_ptr=0 after reset -> gnt sequence 01,02,04,...,80,01; vld follows by latency.
//  3 Wrap: only port7 and port0 requesting, rr_ptr=7 -> gnt 80 then 01 then 80; never multi-hot.
//  4 Reset mid-flight: gnt port3, assert rst next cycle -> no rd_data_vld, busy=0, rr_ptr=0.
//  5 RD_LATENCY=3, grants to ports 1,4,6 on consecutive cycles -> vld 02,10,40 on cycles +3,+4,+5.
//  6 PERF_CNT_EN: 10 cycles of req=8'hFF -> perf_grant_cnt=10, perf_conflict_cnt=10;
//    idle 5 cycles -> unchanged; assert rst -> both 0.
//  Assertions throughout: $onehot0(gnt), $onehot0(rd_data_vld), rd_en[i]==gnt[i].

Source files
------------

// File: rtl/vgpr_rd_port_arbiter_8_pkg.sv
// Shared definitions for the 8-way VGPR read-port arbiter: port/ID/address widths,
// the latency-pipe tag type and a tag-to-one-hot decode helper.
`ifndef VGPR_RD_PORTS
`define VGPR_RD_PORTS 8
`endif
`ifndef VGPR_RD_PORT_ID_W
`define VGPR_RD_PORT_ID_W 3
`endif
`ifndef VGPR_RD_ADDR_W
`define VGPR_RD_ADDR_W 10
`endif

package vgpr_rd_port_arbiter_8_pkg;
    localparam int VGPR_RD_NPORTS = `VGPR_RD_PORTS;
    localparam int VGPR_RD_ID_W   = `VGPR_RD_PORT_ID_W;
    localparam int VGPR_RD_AW     = `VGPR_RD_ADDR_W;

    typedef struct packed {
        logic                    vld;
        logic [VGPR_RD_ID_W-1:0] id;
    } rd_tag_t;

    function automatic logic [VGPR_RD_NPORTS-1:0] tag_to_onehot(input rd_tag_t tag);
        logic [VGPR_RD_NPORTS-1:0] oh;
        oh = '0;
        if (tag.vld) oh[tag.id] = 1'b1;
        return oh;
    endfunction
endpackage

// File: rtl/vgpr_rd_port_arbiter_8_rr_arbiter_8.sv
// Purely combinational 8-way round-robin arbiter: highest priority at ptr, then ptr+1, ... mod 8.
// Reusable for any 8-way register-file port.
module rr_arbiter_8
    import vgpr_rd_port_arbiter_8_pkg::*;
(
    input  logic [7:0] req,
    input  logic [2:0] ptr,
    output logic [7:0] gnt,
    output logic [2:0] gnt_id
);
    logic       w_found;
    logic [2:0] w_idx;

    always_comb begin
        gnt     = '0;
        gnt_id  = '0;
        w_found = 1'b0;
        w_idx   = '0;
        for (int off = 0; off < 8; off++) begin
            w_idx = ptr + 3'(off);
            if (!w_found && req[w_idx]) begin
                w_found     = 1'b1;
                gnt[w_idx]  = 1'b1;
                gnt_id      = w_idx;
            end
        end
    end
endmodule

// File: rtl/vgpr_rd_port_arbiter_8.sv
// Round-robin arbiter feeding rd_port_mux_8to1 with one-hot rd_en/rd_addr and a one-hot data-valid strobe.
// Optional perf counters enabled by defining VGPR_RD_ARB_PERF_CNT_EN.
module vgpr_rd_port_arbiter_8
    import vgpr_rd_port_arbiter_8_pkg::*;
#(
    parameter int NUM_PORTS  = VGPR_RD_NPORTS,
    parameter int ADDR_W     = VGPR_RD_AW,
    parameter int RD_LATENCY = 1
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [NUM_PORTS-1:0]        req,
    input  logic [NUM_PORTS*ADDR_W-1:0] req_addr,
    output logic [NUM_PORTS-1:0]        gnt,
    output logic                        port0_rd_en,
    output logic                        port1_rd_en,
    output logic                        port2_rd_en,
    output logic                        port3_rd_en,
    output logic                        port4_rd_en,
    output logic                        port5_rd_en,
    output logic                        port6_rd_en,
    output logic                        port7_rd_en,
    output logic [ADDR_W-1:0]           port0_rd_addr,
    output logic [ADDR_W-1:0]           port1_rd_addr,
    output logic [ADDR_W-1:0]           port2_rd_addr,
    output logic [ADDR_W-1:0]           port3_rd_addr,
    output logic [ADDR_W-1:0]           port4_rd_addr,
    output logic [ADDR_W-1:0]           port5_rd_addr,
    output logic [ADDR_W-1:0]           port6_rd_addr,
    output logic [ADDR_W-1:0]           port7_rd_addr,
`ifdef VGPR_RD_ARB_PERF_CNT_EN
    output logic [31:0]                 perf_grant_cnt,
    output logic [31:0]                 perf_conflict_cnt,
`endif
    output logic [NUM_PORTS-1:0]        rd_data_vld,
    output logic                        busy
);
    logic [2:0]                             r_rr_ptr;
    logic [RD_LATENCY-1:0]                  r_pipe_vld;
    logic [RD_LATENCY-1:0][VGPR_RD_ID_W-1:0] r_pipe_id;
    logic [NUM_PORTS-1:0]                   r_rd_data_vld;
    logic [NUM_PORTS-1:0]                   w_arb_gnt;
    logic [2:0]                             w_gnt_id;
    logic [NUM_PORTS-1:0]                   w_gnt;
    logic                                   w_any_gnt;
    logic [NUM_PORTS-1:0]                   w_vld_next;
    logic [NUM_PORTS-1:0][ADDR_W-1:0]       w_rd_addr;

    rr_arbiter_8 u_rr_arbiter_8 (
        .req    (req),
        .ptr    (r_rr_ptr),
        .gnt    (w_arb_gnt),
        .gnt_id (w_gnt_id)
    );

    // Grant is suppressed during reset so the mux never sees an enable while state is being cleared
    assign w_gnt     = rst ? w_arb_gnt : '0;
    assign w_any_gnt = |w_gnt;

    // Ungranted slots are masked so garbage on idle req_addr never reaches the mux
    always_comb begin
        for (int i = 0; i < NUM_PORTS; i++)
            w_rd_addr[i] = w_gnt[i] ? req_addr[i*ADDR_W +: ADDR_W] : '0;
    end

    // The strobe register is loaded from the stage feeding the pipe tail, so it lines up with the tail
    generate
        if (RD_LATENCY == 1) begin : g_lat1
            assign w_vld_next = tag_to_onehot('{vld: w_any_gnt, id: w_gnt_id});
        end else begin : g_latn
            assign w_vld_next = tag_to_onehot('{vld: r_pipe_vld[RD_LATENCY-2],
                                                id:  r_pipe_id[RD_LATENCY-2]});
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_rr_ptr      <= '0;
            r_pipe_vld    <= '0;
            r_rd_data_vld <= '0;
        end else begin
            if (w_any_gnt) r_rr_ptr <= w_gnt_id + 3'd1;
            r_pipe_vld[0] <= w_any_gnt;
            for (int i = 1; i < RD_LATENCY; i++)
                r_pipe_vld[i] <= r_pipe_vld[i-1];
            r_rd_data_vld <= w_vld_next;
        end
    end

    always_ff @(posedge clk) begin
        r_pipe_id[0] <= w_gnt_id;
        for (int i = 1; i < RD_LATENCY; i++)
            r_pipe_id[i] <= r_pipe_id[i-1];
    end

`ifdef VGPR_RD_ARB_PERF_CNT_EN
    logic [31:0] r_perf_grant_cnt;
    logic [31:0] r_perf_conflict_cnt;
    logic        w_conflict;

    function automatic logic [31:0] sat_inc(input logic [31:0] v);
        return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
    endfunction

    assign w_conflict = |(req & (req - 1'b1));

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_perf_grant_cnt    <= '0;
            r_perf_conflict_cnt <= '0;
        end else begin
            if (w_any_gnt)  r_perf_grant_cnt    <= sat_inc(r_perf_grant_cnt);
            if (w_conflict) r_perf_conflict_cnt <= sat_inc(r_perf_conflict_cnt);
        end
    end

    assign perf_grant_cnt    = r_perf_grant_cnt;
    assign perf_conflict_cnt = r_perf_conflict_cnt;
`endif

    assign gnt         = w_gnt;
    assign rd_data_vld = r_rd_data_vld;
    assign busy        = |r_pipe_vld;

    assign port0_rd_en = w_gnt[0];
    assign port1_rd_en = w_gnt[1];
    assign port2_rd_en = w_gnt[2];
    assign port3_rd_en = w_gnt[3];
    assign port4_rd_en = w_gnt[4];
    assign port5_rd_en = w_gnt[5];
    assign port6_rd_en = w_gnt[6];
    assign port7_rd_en = w_gnt[7];

    assign port0_rd_addr = w_rd_addr[0];
    assign port1_rd_addr = w_rd_addr[1];
    assign port2_rd_addr = w_rd_addr[2];
    assign port3_rd_addr = w_rd_addr[3];
    assign port4_rd_addr = w_rd_addr[4];
    assign port5_rd_addr = w_rd_addr[5];
    assign port6_rd_addr = w_rd_addr[6];
    assign port7_rd_addr = w_rd_addr[7];
endmodule

// File: tb/tb_vgpr_rd_port_arbiter_8.sv
// Directed bench for vgpr_rd_port_arbiter_8: one instance at RD_LATENCY=1 and one at RD_LATENCY=3
// share the same stimulus; perf counters are exercised when VGPR_RD_ARB_PERF_CNT_EN is defined.
module tb_vgpr_rd_port_arbiter_8;
    logic            clk;
    logic            rst;
    logic [7:0]      req;
    logic [79:0]     req_addr;
    logic [7:0]      gnt1, gnt3, en1, en3, vld1, vld3;
    logic [7:0][9:0] a1, a3;
    logic            busy1, busy3;
    logic [7:0][9:0] ea;
    logic            done;
    int              errors;
    int              checks;
`ifdef VGPR_RD_ARB_PERF_CNT_EN
    logic [31:0]     pg1, pc1, pg3, pc3;
`endif

    vgpr_rd_port_arbiter_8 #(.NUM_PORTS(8), .ADDR_W(10), .RD_LATENCY(1)) dut1 (
        .clk(clk), .rst(rst), .req(req), .req_addr(req_addr), .gnt(gnt1),
        .port0_rd_en(en1[0]), .port1_rd_en(en1[1]), .port2_rd_en(en1[2]), .port3_rd_en(en1[3]),
        .port4_rd_en(en1[4]), .port5_rd_en(en1[5]), .port6_rd_en(en1[6]), .port7_rd_en(en1[7]),
        .port0_rd_addr(a1[0]), .port1_rd_addr(a1[1]), .port2_rd_addr(a1[2]), .port3_rd_addr(a1[3]),
        .port4_rd_addr(a1[4]), .port5_rd_addr(a1[5]), .port6_rd_addr(a1[6]), .port7_rd_addr(a1[7]),
`ifdef VGPR_RD_ARB_PERF_CNT_EN
        .perf_grant_cnt(pg1), .perf_conflict_cnt(pc1),
`endif
        .rd_data_vld(vld1), .busy(busy1)
    );

    vgpr_rd_port_arbiter_8 #(.NUM_PORTS(8), .ADDR_W(10), .RD_LATENCY(3)) dut3 (
        .clk(clk), .rst(rst), .req(req), .req_addr(req_addr), .gnt(gnt3),
        .port0_rd_en(en3[0]), .port1_rd_en(en3[1]), .port2_rd_en(en3[2]), .port3_rd_en(en3[3]),
        .port4_rd_en(en3[4]), .port5_rd_en(en3[5]), .port6_rd_en(en3[6]), .port7_rd_en(en3[7]),
        .port0_rd_addr(a3[0]), .port1_rd_addr(a3[1]), .port2_rd_addr(a3[2]), .port3_rd_addr(a3[3]),
        .port4_rd_addr(a3[4]), .port5_rd_addr(a3[5]), .port6_rd_addr(a3[6]), .port7_rd_addr(a3[7]),
`ifdef VGPR_RD_ARB_PERF_CNT_EN
        .perf_grant_cnt(pg3), .perf_conflict_cnt(pc3),
`endif
        .rd_data_vld(vld3), .busy(busy3)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Continuous invariants, sampled mid-cycle
    always @(negedge clk) begin
        if (!done) begin
            checks++;
            if (!$onehot0(gnt1) || !$onehot0(gnt3)) begin
                errors++;
                $display("FAIL inv_gnt_onehot0 got gnt1=%h gnt3=%h required onehot0", gnt1, gnt3);
            end
            checks++;
            if (!$onehot0(vld1) || !$onehot0(vld3)) begin
                errors++;
                $display("FAIL inv_vld_onehot0 got vld1=%h vld3=%h required onehot0", vld1, vld3);
            end
            checks++;
            if (en1 !== gnt1 || en3 !== gnt3) begin
                errors++;
                $display("FAIL inv_rd_en_eq_gnt got en1=%h gnt1=%h en3=%h gnt3=%h", en1, gnt1, en3, gnt3);
            end
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b0;
        req = 8'h00;
        cyc();
        cyc();
        rst = 1'b1;
    endtask

    task automatic drain();
        req = 8'h00;
        repeat (4) cyc();
    endtask

    task automatic test_reset();
        rst = 1'b0;
        req = 8'hFF;
        req_addr = {8{10'h3A5}};
        cyc();
        cyc();
        #1;
        checks++;
        if (gnt1 !== 8'h00 || gnt3 !== 8'h00) begin
            errors++; $display("FAIL reset_gnt got %h/%h required 00", gnt1, gnt3);
        end
        checks++;
        if (a1 !== '0) begin
            errors++; $display("FAIL reset_addr got %h required 0", a1);
        end
        checks++;
        if (vld1 !== 8'h00 || vld3 !== 8'h00 || busy1 !== 1'b0 || busy3 !== 1'b0) begin
            errors++; $display("FAIL reset_vld_busy got %h %h %b %b required 00 00 0 0", vld1, vld3, busy1, busy3);
        end
        req = 8'h00;
        rst = 1'b1;
        cyc();
    endtask

    task automatic test_single();
        req = 8'h04;
        req_addr = '0;
        req_addr[20 +: 10] = 10'h155;
        ea = '0;
        ea[2] = 10'h155;
        #1;
        checks++;
        if (gnt1 !== 8'h04 || gnt3 !== 8'h04) begin
            errors++; $display("FAIL single_gnt got %h/%h required 04", gnt1, gnt3);
        end
        checks++;
        if (a1 !== ea) begin
            errors++; $display("FAIL single_addr got %h required %h", a1, ea);
        end
        cyc();
        req = 8'h00;
        #1;
        checks++;
        if (gnt1 !== 8'h00 || vld1 !== 8'h04 || busy1 !== 1'b1) begin
            errors++; $display("FAIL single_lat1 got gnt=%h vld=%h busy=%b required 00 04 1", gnt1, vld1, busy1);
        end
        checks++;
        if (vld3 !== 8'h00 || busy3 !== 1'b1) begin
            errors++; $display("FAIL single_lat3_c1 got vld=%h busy=%b required 00 1", vld3, busy3);
        end
        cyc();
        #1;
        checks++;
        if (vld1 !== 8'h00 || busy1 !== 1'b0 || vld3 !== 8'h00 || busy3 !== 1'b1) begin
            errors++; $display("FAIL single_c2 got %h %b %h %b required 00 0 00 1", vld1, busy1, vld3, busy3);
        end
        cyc();
        #1;
        checks++;
        if (vld3 !== 8'h04 || busy3 !== 1'b1) begin
            errors++; $display("FAIL single_lat3_vld got %h %b required 04 1", vld3, busy3);
        end
        cyc();
        #1;
        checks++;
        if (vld3 !== 8'h00 || busy3 !== 1'b0) begin
            errors++; $display("FAIL single_lat3_end got %h %b required 00 0", vld3, busy3);
        end
    endtask

    task automatic test_all_req();
        logic [7:0] eg, ev1, ev3;
        do_reset();
        for (int i = 0; i < 8; i++) req_addr[i*10 +: 10] = 10'h100 + 10'(i);
        req = 8'hFF;
        for (int k = 0; k < 9; k++) begin
            #1;
            eg  = 8'h01 << (k % 8);
            ev1 = (k >= 1) ? (8'h01 << ((k - 1) % 8)) : 8'h00;
            ev3 = (k >= 3) ? (8'h01 << ((k - 3) % 8)) : 8'h00;
            ea = '0;
            ea[k % 8] = 10'h100 + 10'(k % 8);
            checks++;
            if (gnt1 !== eg || gnt3 !== eg) begin
                errors++; $display("FAIL all_gnt k=%0d got %h/%h required %h", k, gnt1, gnt3, eg);
            end
            checks++;
            if (a1 !== ea) begin
                errors++; $display("FAIL all_addr k=%0d got %h required %h", k, a1, ea);
            end
            checks++;
            if (vld1 !== ev1 || vld3 !== ev3) begin
                errors++; $display("FAIL all_vld k=%0d got %h/%h required %h/%h", k, vld1, vld3, ev1, ev3);
            end
            cyc();
        end
        drain();
    endtask

    task automatic test_wrap();
        req = 8'h40;
        #1;
        checks++;
        if (gnt1 !== 8'h40) begin
            errors++; $display("FAIL wrap_setup got %h required 40", gnt1);
        end
        cyc();
        req = 8'h81;
        #1;
        checks++;
        if (gnt1 !== 8'h80) begin
            errors++; $display("FAIL wrap_g0 got %h required 80", gnt1);
        end
        cyc();
        #1;
        checks++;
        if (gnt1 !== 8'h01) begin
            errors++; $display("FAIL wrap_g1 got %h required 01", gnt1);
        end
        cyc();
        #1;
        checks++;
        if (gnt1 !== 8'h80) begin
            errors++; $display("FAIL wrap_g2 got %h required 80", gnt1);
        end
        cyc();
        drain();
    endtask

    task automatic test_reset_midflight();
        req = 8'h08;
        #1;
        checks++;
        if (gnt3 !== 8'h08) begin
            errors++; $display("FAIL mid_gnt got %h required 08", gnt3);
        end
        cyc();
        req = 8'h00;
        rst = 1'b0;
        #1;
        checks++;
        if (busy3 !== 1'b1) begin
            errors++; $display("FAIL mid_busy_before got %b required 1", busy3);
        end
        cyc();
        #1;
        checks++;
        if (vld3 !== 8'h00 || busy3 !== 1'b0 || busy1 !== 1'b0 || vld1 !== 8'h00) begin
            errors++; $display("FAIL mid_cleared got %h %b %b %h required 00 0 0 00", vld3, busy3, busy1, vld1);
        end
        rst = 1'b1;
        for (int k = 0; k < 3; k++) begin
            cyc();
            #1;
            checks++;
            if (vld3 !== 8'h00) begin
                errors++; $display("FAIL mid_no_vld k=%0d got %h required 00", k, vld3);
            end
        end
        req = 8'hFF;
        #1;
        checks++;
        if (gnt1 !== 8'h01 || gnt3 !== 8'h01) begin
            errors++; $display("FAIL mid_ptr_reset got %h/%h required 01", gnt1, gnt3);
        end
        cyc();
        drain();
    endtask

    task automatic test_latency3();
        logic [7:0] sreq [6];
        logic [7:0] eg [6];
        logic [7:0] e1 [6];
        logic [7:0] e3 [6];
        sreq = '{8'h02, 8'h10, 8'h40, 8'h00, 8'h00, 8'h00};
        eg   = '{8'h02, 8'h10, 8'h40, 8'h00, 8'h00, 8'h00};
        e1   = '{8'h00, 8'h02, 8'h10, 8'h40, 8'h00, 8'h00};
        e3   = '{8'h00, 8'h00, 8'h00, 8'h02, 8'h10, 8'h40};
        for (int k = 0; k < 6; k++) begin
            req = sreq[k];
            #1;
            checks++;
            if (gnt3 !== eg[k] || vld1 !== e1[k] || vld3 !== e3[k]) begin
                errors++;
                $display("FAIL lat3 k=%0d got gnt=%h vld1=%h vld3=%h required %h %h %h",
                         k, gnt3, vld1, vld3, eg[k], e1[k], e3[k]);
            end
            cyc();
        end
        #1;
        checks++;
        if (vld3 !== 8'h00 || busy3 !== 1'b0) begin
            errors++; $display("FAIL lat3_end got %h %b required 00 0", vld3, busy3);
        end
    endtask

    task automatic test_back_to_back();
        req = 8'h02;
        for (int k = 0; k < 3; k++) begin
            #1;
            checks++;
            if (gnt1 !== 8'h02 || vld1 !== ((k > 0) ? 8'h02 : 8'h00)) begin
                errors++; $display("FAIL b2b k=%0d got gnt=%h vld=%h", k, gnt1, vld1);
            end
            cyc();
        end
        drain();
    endtask

`ifdef VGPR_RD_ARB_PERF_CNT_EN
    task automatic test_perf();
        do_reset();
        #1;
        checks++;
        if (pg1 !== 32'd0 || pc1 !== 32'd0) begin
            errors++; $display("FAIL perf_init got %0d %0d required 0 0", pg1, pc1);
        end
        req = 8'hFF;
        repeat (10) cyc();
        req = 8'h00;
        #1;
        checks++;
        if (pg1 !== 32'd10 || pc1 !== 32'd10 || pg3 !== 32'd10 || pc3 !== 32'd10) begin
            errors++; $display("FAIL perf_count got %0d %0d required 10 10", pg1, pc1);
        end
        repeat (5) cyc();
        #1;
        checks++;
        if (pg1 !== 32'd10 || pc1 !== 32'd10) begin
            errors++; $display("FAIL perf_idle got %0d %0d required 10 10", pg1, pc1);
        end
        rst = 1'b0;
        cyc();
        #1;
        checks++;
        if (pg1 !== 32'd0 || pc1 !== 32'd0) begin
            errors++; $display("FAIL perf_rst got %0d %0d required 0 0", pg1, pc1);
        end
        rst = 1'b1;
        cyc();
    endtask
`endif

    initial begin
        errors   = 0;
        checks   = 0;
        done     = 1'b0;
        rst      = 1'b0;
        req      = 8'h00;
        req_addr = '0;
        ea       = '0;
        test_reset();
        test_single();
        test_all_req();
        test_wrap();
        test_reset_midflight();
        test_latency3();
        test_back_to_back();
`ifdef VGPR_RD_ARB_PERF_CNT_EN
        test_perf();
`endif
        done = 1'b1;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
